// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts one byte plus odd parity out on device clock falls and checks the ack.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750_000,
    parameter int CNT_SIZE       = 20
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_DATA,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    localparam logic [CNT_SIZE-1:0] INH_TC  = CNT_SIZE'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_SIZE-1:0] TMO_TC  = CNT_SIZE'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_SIZE-1:0] CNT_ONE = CNT_SIZE'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_clk_sync;
    logic [1:0]          r_data_sync;
    logic                r_clk_prev;
    logic [CNT_SIZE-1:0] r_cnt;
    logic [CNT_SIZE-1:0] w_cnt_nxt;
    logic [3:0]          r_bitcnt;
    logic [3:0]          w_bitcnt_nxt;
    logic [9:0]          r_shift;
    logic [9:0]          w_shift_nxt;
    logic                r_data_oe;
    logic                w_data_oe_nxt;
    logic                r_ack_err;
    logic                w_ack_err_nxt;
    logic                w_clk_s;
    logic                w_data_s;
    logic                w_fall;
    logic                w_tmo;

    // Synchronisers reset to the idle-high bus level so reset never fakes a fall.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk_in};
            r_data_sync <= {r_data_sync[0], ps2_data_in};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    assign w_clk_s  = r_clk_sync[1];
    assign w_data_s = r_data_sync[1];
    assign w_fall   = r_clk_prev & ~w_clk_s;
    assign ack_err  = r_ack_err;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_data_oe <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_shift   <= w_shift_nxt;
            r_data_oe <= w_data_oe_nxt;
            r_ack_err <= w_ack_err_nxt;
        end
    end

    // OEs are decoded from state, so an async reset releases both pads at once.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a value unassigned and infer a latch.
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bitcnt_nxt  = r_bitcnt;
        w_shift_nxt   = r_shift;
        w_data_oe_nxt = r_data_oe;
        w_ack_err_nxt = r_ack_err;
        ps2_clk_oe    = 1'b0;
        ps2_data_oe   = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        timeout_err   = 1'b0;
        w_tmo         = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy          = 1'b0;
                w_data_oe_nxt = 1'b0;
                if (tx_start) begin
                    w_shift_nxt   = {1'b1, ~^tx_data, tx_data};
                    w_cnt_nxt     = '0;
                    w_bitcnt_nxt  = '0;
                    w_ack_err_nxt = 1'b0;
                    w_state_nxt   = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (r_cnt == INH_TC) begin
                    // Start bit goes low while the clock is still held.
                    ps2_data_oe   = 1'b1;
                    w_data_oe_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_bitcnt_nxt  = '0;
                    w_state_nxt   = S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            S_DATA: begin
                ps2_data_oe = r_data_oe;
                w_cnt_nxt   = r_cnt + CNT_ONE;
                if (w_fall) begin
                    w_data_oe_nxt = ~r_shift[r_bitcnt];
                    w_bitcnt_nxt  = r_bitcnt + 4'd1;
                    if (r_bitcnt == 4'd9) begin
                        w_state_nxt = S_ACK;
                    end
                end
            end

            S_ACK: begin
                w_cnt_nxt = r_cnt + CNT_ONE;
                if (w_fall) begin
                    w_ack_err_nxt = w_data_s;
                    w_state_nxt   = S_WAIT_IDLE;
                end
            end

            S_WAIT_IDLE: begin
                w_cnt_nxt = r_cnt + CNT_ONE;
                if (w_clk_s && w_data_s) begin
                    done        = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // The timeout overrides whatever the device did on the same cycle.
        if ((r_state == S_DATA || r_state == S_ACK || r_state == S_WAIT_IDLE) &&
            (r_cnt == TMO_TC)) begin
            w_tmo = 1'b1;
        end
        if (w_tmo) begin
            ps2_data_oe   = 1'b0;
            done          = 1'b0;
            timeout_err   = 1'b1;
            w_data_oe_nxt = 1'b0;
            w_ack_err_nxt = r_ack_err;
            w_state_nxt   = S_IDLE;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks frames out of
// the host and compares what it sees against frames built from the byte itself.
module tb_ps2_host_tx;

    localparam int INHIBIT_CYCLES = 50;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int CNT_SIZE       = 12;
    localparam int HALF           = 20;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state, sampled on the falling clock edge.
    int cyc = 0;
    int inh_starts = 0;
    int inh_len = 0;
    int inh_overlap = 0;
    int last_inh_data = 0;
    int t_release = 0;
    int t_timeout = 0;
    int done_cnt = 0;
    int done_ack_err = 0;
    int to_cnt = 0;
    int to_oe = 0;
    logic prev_clk_oe = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_SIZE      (CNT_SIZE)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err),
        .timeout_err(timeout_err)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (ps2_clk_oe) begin
            if (!prev_clk_oe) begin
                inh_starts++;
                inh_len     = 0;
                inh_overlap = 0;
            end
            inh_len++;
            if (ps2_data_oe) inh_overlap++;
            last_inh_data = int'(ps2_data_oe);
        end
        if (!ps2_clk_oe && prev_clk_oe) t_release = cyc;
        if (done) begin
            done_cnt++;
            done_ack_err = int'(ack_err);
        end
        if (timeout_err) begin
            to_cnt++;
            t_timeout = cyc;
            to_oe     = int'(ps2_clk_oe | ps2_data_oe);
        end
        prev_clk_oe = ps2_clk_oe;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit ref_parity(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    task automatic start_tx(input logic [7:0] d);
        @(posedge clk); #1;
        tx_data  = d;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_ack_err_clear", ack_err, 0);
    endtask

    // Device side: waits for request-to-send, then generates n_falls clock pulses,
    // sampling data on each rising edge and acking the stop bit if asked to.
    task automatic device_xfer(input bit do_ack, input int n_falls, input int inject_at,
                               output logic [10:0] seen, output bit rts_ok);
        int n;
        seen   = '0;
        rts_ok = 1'b0;
        n      = 0;
        while (ps2_clk_oe && n < INHIBIT_CYCLES + 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (ps2_clk_oe) return;
        rts_ok = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
        seen[0] = ps2_data_in;
        for (int k = 1; k <= n_falls; k++) begin
            dev_clk_low = 1'b1;
            if (k == n_falls && n_falls < 11) begin
                repeat (5) @(posedge clk);
                #1;
                return;
            end
            repeat (HALF) @(posedge clk);
            #1;
            dev_clk_low = 1'b0;
            if (k <= 10) seen[k] = ps2_data_in;
            if (k == 10 && do_ack) dev_data_low = 1'b1;
            if (k == 11) dev_data_low = 1'b0;
            if (k == inject_at) begin
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(posedge clk); #1;
                tx_start = 1'b0;
                repeat (HALF - 1) @(posedge clk);
                #1;
            end else begin
                repeat (HALF) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input bit do_ack, input bit exp_par,
                             input bit exp_ack_err, input int inject_at);
        logic [10:0] seen;
        bit          rts_ok;
        int          d0;
        int          s0;
        int          n;
        d0 = done_cnt;
        s0 = inh_starts;
        start_tx(d);
        device_xfer(do_ack, 11, inject_at, seen, rts_ok);
        check("rts_seen", rts_ok, 1);
        check("inhibit_len", inh_len, INHIBIT_CYCLES);
        check("inhibit_start_overlap", inh_overlap, 1);
        check("inhibit_tc_data", last_inh_data, 1);
        check("start_bit", seen[0], 0);
        check("data_bits", seen[8:1], d);
        check("parity_bit", seen[9], exp_par);
        check("stop_bit", seen[10], 1);
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("busy_drop", busy, 0);
        check("done_pulses", done_cnt - d0, 1);
        check("done_ack_err", done_ack_err, exp_ack_err);
        repeat (2 * INHIBIT_CYCLES) @(posedge clk);
        #1;
        check("ack_err_hold", ack_err, exp_ack_err);
        check("no_extra_transfer", inh_starts - s0, 1);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         exp_par;
        bit         exp_ack_err;
        int         inject_at;
    } vec_t;

    initial begin
        vec_t        vecs [5];
        logic [10:0] seen;
        bit          rts_ok;
        int          t0;
        int          d0;
        int          n;
        logic [7:0]  rd;
        bit          rack;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b0, 0};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 0};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 0};
        vecs[3] = '{8'hA5, 1'b0, 1'b1, 1'b1, 0};
        vecs[4] = '{8'h9A, 1'b1, 1'b1, 1'b0, 5};

        #1;
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_timeout", timeout_err, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].data, vecs[i].ack, vecs[i].exp_par, vecs[i].exp_ack_err,
                      vecs[i].inject_at);
        end

        for (int i = 0; i < 4; i++) begin
            rd   = 8'($urandom_range(0, 255));
            rack = 1'($urandom_range(0, 1));
            run_frame(rd, rack, ref_parity(rd), !rack, 0);
        end

        // Device never clocks: host must abort on its own.
        t0 = to_cnt;
        d0 = done_cnt;
        start_tx(8'h3C);
        n = 0;
        while (to_cnt == t0 && n < INHIBIT_CYCLES + TIMEOUT_CYCLES + 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("tmo_pulse", to_cnt - t0, 1);
        check("tmo_latency", t_timeout - t_release, TIMEOUT_CYCLES - 1);
        check("tmo_oe_released", to_oe, 0);
        check("tmo_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        check("tmo_single_pulse", to_cnt - t0, 1);
        check("tmo_no_done", done_cnt - d0, 0);

        // Reset after the 4th fall: d3 of 0xF7 is 0, so data is being pulled low.
        start_tx(8'hF7);
        device_xfer(1'b1, 4, 0, seen, rts_ok);
        check("pre_reset_rts", rts_ok, 1);
        check("pre_reset_data_oe", ps2_data_oe, 1);
        rst_b = 1'b0;
        #1;
        check("async_rst_clk_oe", ps2_clk_oe, 0);
        check("async_rst_data_oe", ps2_data_oe, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_ack_err", ack_err, 0);
        check("async_rst_timeout", timeout_err, 0);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_b = 1'b1;
        repeat (5) @(posedge clk);
        run_frame(8'hFF, 1'b1, ref_parity(8'hFF), 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
